// File: rtl/screen_pkg.sv
// screen_pkg: shared state encodings, screen geometry and colour constants
package screen_pkg;
  typedef enum logic [1:0] {
    TITLE        = 2'b00,
    PLAYING      = 2'b01,
    GAME_OVER    = 2'b10,
    WAIT_RELEASE = 2'b11
  } screen_state_e;
  localparam int SCREEN_WIDTH = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam logic [4:0] COLOR_BLACK = 5'd0;
endpackage

// File: rtl/screen_sequencer_switch_debouncer.sv
// switch_debouncer: two-flop synchronizer, stability counter and edge detect for the start switch
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_in,
  output logic sw_db,
  output logic rise,
  output logic fall
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic db_q, db_d, db_prev_q;
  logic match, done;
  always_comb begin
    match = sync_q[1] == db_q;
    done = cnt_q == CNT_MAX;
    cnt_d = (match || done) ? '0 : cnt_q + 1'b1;
    db_d = (!match && done) ? ~db_q : db_q;
  end
  // Synchronizer and debounced value reset high so a switch held through reset reads as already on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q <= '0;
      db_q <= 1'b1;
      db_prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], sw_in};
      cnt_q <= cnt_d;
      db_q <= db_d;
      db_prev_q <= db_q;
    end
  end
  assign sw_db = db_q;
  assign rise = db_q & ~db_prev_q;
  assign fall = ~db_q & db_prev_q;
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: title/playing/game-over sequencing, flicker phase and frame-aligned RGB source select
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int FLICKER_FRAMES = 15,
  parameter int OVER_FRAMES = 180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_sw,
  input  logic        game_over,
  input  logic        video_on,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic [4:0]  title_rgb,
  input  logic [4:0]  game_rgb,
  input  logic [4:0]  over_rgb,
  output logic [4:0]  vga_rgb,
  output logic [1:0]  frame_tick,
  output logic        game_reset,
  output logic        game_active,
  output logic [1:0]  state
);
  localparam int FW = FLICKER_FRAMES > 1 ? $clog2(FLICKER_FRAMES) : 1;
  localparam int OW = OVER_FRAMES > 1 ? $clog2(OVER_FRAMES) : 1;
  localparam logic [FW-1:0] FCNT_MAX = FW'(FLICKER_FRAMES - 1);
  localparam logic [OW-1:0] OCNT_MAX = OW'(OVER_FRAMES - 1);
  logic sw_db, sw_rise, sw_fall;
  logic fcond_q, fcond_prev_q, frame_strobe, flick_wrap;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [OW-1:0] ocnt_q, ocnt_d;
  logic [1:0] tick_q, tick_d;
  screen_state_e state_q, state_d, disp_q, disp_d;
  logic [4:0] vga_q, vga_d;
  logic game_reset_q, game_reset_d;
  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
    .clk(clk),
    .rst_n(rst_n),
    .sw_in(start_sw),
    .sw_db(sw_db),
    .rise(sw_rise),
    .fall(sw_fall)
  );
  // One pulse per frame regardless of how many clk cycles the strobe pixel is held
  assign frame_strobe = fcond_q & ~fcond_prev_q;
  assign flick_wrap = frame_strobe && fcnt_q == FCNT_MAX;
  always_comb begin
    state_d = state_q;
    ocnt_d = ocnt_q;
    case (state_q)
      TITLE: state_d = sw_rise ? PLAYING : TITLE;
      PLAYING: begin
        ocnt_d = '0;
        state_d = game_over ? GAME_OVER : sw_fall ? TITLE : PLAYING;
      end
      GAME_OVER: begin
        ocnt_d = frame_strobe ? ocnt_q + 1'b1 : ocnt_q;
        state_d = (frame_strobe && ocnt_q == OCNT_MAX) ? WAIT_RELEASE : GAME_OVER;
      end
      default: state_d = sw_db ? WAIT_RELEASE : TITLE;
    endcase
    game_reset_d = state_q == TITLE && sw_rise;
    fcnt_d = flick_wrap ? '0 : frame_strobe ? fcnt_q + 1'b1 : fcnt_q;
    tick_d = tick_q + {1'b0, flick_wrap};
    disp_d = frame_strobe ? state_q : disp_q;
    vga_d = !video_on ? COLOR_BLACK :
            disp_q == TITLE ? title_rgb :
            disp_q == PLAYING ? game_rgb : over_rgb;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcond_q <= 1'b0;
      fcond_prev_q <= 1'b0;
      fcnt_q <= '0;
      ocnt_q <= '0;
      tick_q <= '0;
      state_q <= TITLE;
      disp_q <= TITLE;
      vga_q <= COLOR_BLACK;
      game_reset_q <= 1'b0;
    end else begin
      fcond_q <= pixel_x == 11'd0 && pixel_y == 11'(SCREEN_HEIGHT);
      fcond_prev_q <= fcond_q;
      fcnt_q <= fcnt_d;
      ocnt_q <= ocnt_d;
      tick_q <= tick_d;
      state_q <= state_d;
      disp_q <= disp_d;
      vga_q <= vga_d;
      game_reset_q <= game_reset_d;
    end
  end
  assign vga_rgb = vga_q;
  assign frame_tick = tick_q;
  assign game_reset = game_reset_q;
  assign game_active = state_q == PLAYING;
  assign state = state_q;
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed scenarios plus randomized run against a behavioural screen model
module tb_screen_sequencer;
  localparam int D = 4, F = 2, O = 3;
  localparam int T = 0, P = 1, G = 2, W = 3;
  logic clk = 0, rst_n = 0, start_sw = 1, game_over = 0, video_on = 0;
  logic [10:0] pixel_x = 11'd5, pixel_y = 11'd5;
  logic [4:0] title_rgb = '0, game_rgb = '0, over_rgb = '0;
  logic [4:0] vga_rgb;
  logic [1:0] frame_tick, state;
  logic game_reset, game_active;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  screen_sequencer #(.DEBOUNCE_CYCLES(D), .FLICKER_FRAMES(F), .OVER_FRAMES(O)) dut (
    .clk(clk), .rst_n(rst_n), .start_sw(start_sw), .game_over(game_over),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .title_rgb(title_rgb), .game_rgb(game_rgb), .over_rgb(over_rgb),
    .vga_rgb(vga_rgb), .frame_tick(frame_tick), .game_reset(game_reset),
    .game_active(game_active), .state(state)
  );

  // Behavioural model: the switch is seen through a 2-deep sample history, the debounced
  // value flips after D consecutive disagreeing samples, flicker phase is strobes/F mod 4,
  // and game over lasts until the O-th strobe seen in that screen.
  int m_state = T, m_ov = 0, m_disp = T, m_strobes = 0, m_run = 0, m_nxt;
  logic [4:0] m_vga = '0;
  bit m_gr = 0, m_db = 1, m_dbp = 1, m_fc = 0, m_fcp = 0, m_rise, m_fall, m_strobe;
  bit hist[$] = '{1'b1, 1'b1};

  function automatic int m_tick();
    return (m_strobes / F) % 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = T; m_ov = 0; m_disp = T; m_strobes = 0; m_run = 0; m_vga = '0; m_gr = 0;
      m_db = 1; m_dbp = 1; m_fc = 0; m_fcp = 0; hist = '{1'b1, 1'b1};
    end else begin
      m_rise = m_db && !m_dbp;
      m_fall = !m_db && m_dbp;
      m_strobe = m_fc && !m_fcp;
      m_nxt = m_state;
      if (m_state == T && m_rise) m_nxt = P;
      if (m_state == P) begin
        if (game_over) begin m_nxt = G; m_ov = 0; end
        else if (m_fall) m_nxt = T;
      end
      if (m_state == G && m_strobe) begin
        m_ov++;
        if (m_ov == O) m_nxt = W;
      end
      if (m_state == W && !m_db) m_nxt = T;
      m_gr = m_state == T && m_rise;
      m_vga = !video_on ? 5'd0 : m_disp == T ? title_rgb : m_disp == P ? game_rgb : over_rgb;
      if (m_strobe) begin m_disp = m_state; m_strobes++; end
      m_dbp = m_db;
      if (hist[0] == m_db) m_run = 0;
      else begin
        m_run++;
        if (m_run == D) begin m_db = !m_db; m_run = 0; end
      end
      void'(hist.pop_front());
      hist.push_back(start_sw);
      m_fcp = m_fc;
      m_fc = pixel_x == 11'd0 && pixel_y == 11'd480;
      m_state = m_nxt;
    end
  end

  task automatic mid_pixel();
    pixel_x = 11'($urandom_range(1, 639));
    pixel_y = 11'($urandom_range(0, 524));
  endtask

  task automatic strobe_pixel();
    pixel_x = 11'd0;
    pixel_y = 11'd480;
  endtask

  task automatic test_reset();
    rst_n = 0; start_sw = 1; game_over = 0; video_on = 0;
    repeat (3) @(negedge clk);
    checks++; if (vga_rgb !== 5'd0) begin errors++; $display("FAIL reset_vga: got %0d expected 0", vga_rgb); end
    checks++; if (frame_tick !== 2'd0) begin errors++; $display("FAIL reset_tick: got %0d expected 0", frame_tick); end
    checks++; if (game_reset !== 1'b0) begin errors++; $display("FAIL reset_game_reset: got %0d expected 0", game_reset); end
    checks++; if (game_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %0d expected 0", game_active); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    rst_n = 1;
  endtask

  task automatic test_flicker();
    logic [1:0] seq[$];
    logic [1:0] last = 2'd0;
    bit vo_prev = video_on;
    int k;
    for (int f = 0; f < 8; f++) begin
      k = $urandom_range(1, 3);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        checks++; if (frame_tick !== 2'(m_tick())) begin errors++; $display("FAIL flicker_tick: got %0d expected %0d", frame_tick, m_tick()); end
        checks++; if (vga_rgb !== m_vga) begin errors++; $display("FAIL flicker_vga: got %0d expected %0d", vga_rgb, m_vga); end
        if (!vo_prev) begin
          checks++; if (vga_rgb !== 5'd0) begin errors++; $display("FAIL flicker_blank: got %0d expected 0", vga_rgb); end
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL held_switch_state: got %0d expected 0", state); end
        if (frame_tick !== last) begin seq.push_back(frame_tick); last = frame_tick; end
        if (c < k) strobe_pixel(); else mid_pixel();
        video_on = 1'($urandom);
        title_rgb = 5'($urandom); game_rgb = 5'($urandom); over_rgb = 5'($urandom);
        vo_prev = video_on;
      end
    end
    checks++; if (seq.size() != 4) begin errors++; $display("FAIL flicker_steps: got %0d expected 4", seq.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (seq[i] !== 2'((i + 1) % 4)) begin errors++; $display("FAIL flicker_seq%0d: got %0d expected %0d", i, seq[i], (i + 1) % 4); end
      end
    end
  endtask

  task automatic test_debounce();
    int gr_cnt = 0;
    bit seen = 0;
    title_rgb = 5'b11000; game_rgb = 5'b00111; over_rgb = 5'b10101; video_on = 1;
    pixel_x = 11'd100; pixel_y = 11'd200;
    @(negedge clk);
    start_sw = 0;
    repeat (3) @(negedge clk);
    start_sw = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL glitch_state: got %0d expected 0", state); end
      checks++; if (game_reset !== 1'b0) begin errors++; $display("FAIL glitch_game_reset: got %0d expected 0", game_reset); end
    end
    start_sw = 0;
    repeat (8) @(negedge clk);
    start_sw = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gr_cnt += int'(game_reset);
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL debounce_state: got %0d expected %0d", state, m_state); end
      if (!seen && state == 2'd1) begin
        seen = 1;
        checks++; if (game_reset !== 1'b1) begin errors++; $display("FAIL start_pulse: got %0d expected 1", game_reset); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL start_timeout: got state %0d expected 1", state); end
    checks++; if (gr_cnt != 1) begin errors++; $display("FAIL start_pulse_width: got %0d expected 1", gr_cnt); end
  endtask

  task automatic test_frame_aligned();
    repeat (2) begin
      @(negedge clk);
      checks++; if (vga_rgb !== 5'b11000) begin errors++; $display("FAIL pre_strobe_vga: got %b expected 11000", vga_rgb); end
    end
    strobe_pixel();
    @(negedge clk);
    pixel_x = 11'd100; pixel_y = 11'd200;
    checks++; if (vga_rgb !== 5'b11000) begin errors++; $display("FAIL strobe_edge1_vga: got %b expected 11000", vga_rgb); end
    @(negedge clk);
    checks++; if (vga_rgb !== 5'b11000) begin errors++; $display("FAIL strobe_edge2_vga: got %b expected 11000", vga_rgb); end
    @(negedge clk);
    checks++; if (vga_rgb !== 5'b00111) begin errors++; $display("FAIL post_strobe_vga: got %b expected 00111", vga_rgb); end
    checks++; if (vga_rgb !== m_vga) begin errors++; $display("FAIL post_strobe_model: got %b expected %b", vga_rgb, m_vga); end
  endtask

  task automatic test_game_over();
    bit seen = 0;
    game_over = 1;
    @(negedge clk);
    game_over = 0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL over_state: got %0d expected 2", state); end
    checks++; if (game_active !== 1'b0) begin errors++; $display("FAIL over_active: got %0d expected 0", game_active); end
    for (int f = 0; f < 3; f++) begin
      if (f == 2) begin
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL over_early_exit: got %0d expected 2", state); end
      end
      strobe_pixel();
      @(negedge clk);
      mid_pixel();
      repeat (4) @(negedge clk);
    end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL wait_release_state: got %0d expected 3", state); end
    checks++; if (vga_rgb !== 5'b10101) begin errors++; $display("FAIL over_vga: got %b expected 10101", vga_rgb); end
    start_sw = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL release_state: got %0d expected %0d", state, m_state); end
      seen = state == 2'd0;
    end
    checks++; if (!seen) begin errors++; $display("FAIL release_timeout: got %0d expected 0", state); end
  endtask

  task automatic test_simultaneous();
    bit seen = 0;
    start_sw = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = state == 2'd1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL replay_timeout: got %0d expected 1", state); end
    start_sw = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !m_db && m_dbp;
    end
    checks++; if (!seen) begin errors++; $display("FAIL fall_timeout: got no fall expected fall"); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL pre_sim_state: got %0d expected 1", state); end
    game_over = 1;
    @(negedge clk);
    game_over = 0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL sim_priority: got %0d expected 2", state); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if (vga_rgb !== 5'd0) begin errors++; $display("FAIL mid_reset_vga: got %0d expected 0", vga_rgb); end
    checks++; if (frame_tick !== 2'd0) begin errors++; $display("FAIL mid_reset_tick: got %0d expected 0", frame_tick); end
    checks++; if (game_reset !== 1'b0) begin errors++; $display("FAIL mid_reset_game_reset: got %0d expected 0", game_reset); end
    checks++; if (game_active !== 1'b0) begin errors++; $display("FAIL mid_reset_active: got %0d expected 0", game_active); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_reset_state: got %0d expected 0", state); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL post_reset_state: got %0d expected 0", state); end
      checks++; if (game_reset !== 1'b0) begin errors++; $display("FAIL post_reset_pulse: got %0d expected 0", game_reset); end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rand_state: got %0d expected %0d", state, m_state); end
      checks++; if (vga_rgb !== m_vga) begin errors++; $display("FAIL rand_vga: got %0d expected %0d", vga_rgb, m_vga); end
      checks++; if (frame_tick !== 2'(m_tick())) begin errors++; $display("FAIL rand_tick: got %0d expected %0d", frame_tick, m_tick()); end
      checks++; if (game_reset !== m_gr) begin errors++; $display("FAIL rand_game_reset: got %0d expected %0d", game_reset, m_gr); end
      checks++; if (game_active !== (m_state == P)) begin errors++; $display("FAIL rand_active: got %0d expected %0d", game_active, m_state == P); end
      if (hold == 0) begin start_sw = ~start_sw; hold = $urandom_range(1, 12); end
      else hold--;
      game_over = $urandom_range(0, 15) == 0;
      if (i % 12 < 1 || (i % 12 == 1 && $urandom_range(0, 1) == 1)) strobe_pixel(); else mid_pixel();
      video_on = 1'($urandom);
      title_rgb = 5'($urandom); game_rgb = 5'($urandom); over_rgb = 5'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_flicker();
    test_debounce();
    test_frame_aligned();
    test_game_over();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Top-level screen controller for the Space Invaders display path. Sequences the game through title, playing and game-over screens, and debounces the start switch. Generates the 2-bit `frame_tick` flicker phase consumed by the title text generators. Selects which RGB source (title, game, game-over) drives the VGA output, switching only on frame boundaries so the screen never tears.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: clk cycles the synchronized switch must stay stable before the debounced value changes (10 ms at 100 MHz).
- `FLICKER_FRAMES`, 15: frame strobes per `frame_tick` increment.
- `OVER_FRAMES`, 180: frame strobes the game-over screen is held (3 s at 60 Hz).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_sw` in 1: raw start switch, asynchronous to clk.
- `game_over` in 1: level from game logic, player lost.
- `video_on` in 1: active-video flag from the VGA timing generator.
- `pixel_x`, `pixel_y` in 11 each: current pixel coordinates.
- `title_rgb`, `game_rgb`, `over_rgb` in 5 each: candidate pixel colors.
- `vga_rgb` out 5: registered output color.
- `frame_tick` out 2: flicker phase.
- `game_reset` out 1: one-cycle pulse that clears game state.
- `game_active` out 1: high while in PLAYING.
- `state` out 2: current FSM state, for debug LEDs.

## Operation
- **Switch synchronizer and debouncer**
  - `start_sw` passes through 2 flops, producing `sw_sync`.
  - The counter clears whenever `sw_sync == sw_db`.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, `sw_db` toggles and the counter clears.
  - `sw_db` resets to 1, so a switch held high through reset never starts a game.
  - `sw_rise` and `sw_fall` are single-cycle edges of `sw_db`.
- **Frame strobe**
  - `fcond = (pixel_x == 0 && pixel_y == 480)`, registered each cycle.
  - `frame_strobe` = rising edge of the registered `fcond`. This gives exactly one clk pulse per frame, independent of the pixel-clock divider.
- **Flicker**
  - `fcnt` counts frame strobes from 0 to FLICKER_FRAMES-1.
  - On wrap, `frame_tick` increments, wrapping 3→0.
  - Flicker runs in every state.
- **FSM** (encodings: TITLE=00, PLAYING=01, GAME_OVER=10, WAIT_RELEASE=11)
  - TITLE: on `sw_rise` → PLAYING, and `game_reset` pulses in the same cycle as the transition.
  - PLAYING:
    - `game_over` high → GAME_OVER, with `ocnt` cleared.
    - Otherwise `sw_fall` → TITLE (abort).
    - `game_over` has priority when both occur in the same cycle.
  - GAME_OVER: `ocnt` increments on each frame strobe. When `ocnt == OVER_FRAMES-1` and a strobe occurs → WAIT_RELEASE.
  - WAIT_RELEASE:
    - `sw_db == 0` → TITLE.
    - `sw_rise` is impossible here. If the switch is already low, the transition happens on the next cycle.
- **Display select**
  - `disp_sel` is a copy of `state`, loaded only on `frame_strobe`.
  - `vga_rgb` is registered:
    - 0 when `!video_on`;
    - `title_rgb` when `disp_sel` is TITLE;
    - `game_rgb` when PLAYING;
    - `over_rgb` when GAME_OVER or WAIT_RELEASE.
- `game_active = (state == PLAYING)`, decoded combinationally from the state register.

## Timing
- Reset values:
  - `vga_rgb` = 0, `frame_tick` = 0, `game_reset` = 0, `game_active` = 0, `state` = TITLE.
  - `disp_sel` = TITLE, `sw_db` = 1.
  - All counters = 0.
- `vga_rgb` latency: 1 clk from the `video_on`/rgb inputs.
- Switch-to-`sw_db` latency: 2 (sync) + DEBOUNCE_CYCLES clks.
- `state` changes 1 clk after the qualifying event.
- `disp_sel` follows `state` at the next frame strobe, so the worst-case visible delay is 1 frame.
- Glitches shorter than DEBOUNCE_CYCLES are rejected; any bounce restarts the count.
- Reset mid-game: everything returns to TITLE, and no `game_reset` pulse is generated.

## Structure
- Package `screen_pkg` holds:
  - the state encodings;
  - SCREEN_WIDTH=640 and SCREEN_HEIGHT=480 (the frame strobe row);
  - COLOR_BLACK.
- Sub-module `switch_debouncer` (parameter DEBOUNCE_CYCLES; ports `clk`, `rst_n`, `sw_in`, `sw_db`, `rise`, `fall`) contains the synchronizer, counter and edge detect.
- The frame strobe, flicker counter, FSM and output mux live in `screen_sequencer`.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, FLICKER_FRAMES=2, OVER_FRAMES=3.
- **Flicker:** reset, then sweep pixel coordinates across 8 frames → `frame_tick` steps 0,1,2,3,0 every 2 strobes; `vga_rgb` = 0 whenever `video_on` = 0.
- **Debounce:** hold `start_sw` high through reset → stays in TITLE. Pulse low 3 clks → no change. Hold low ≥6 clks, then high ≥6 clks → PLAYING, with `game_reset` high exactly 1 clk.
- **Frame-aligned display:** enter PLAYING mid-frame with `game_rgb=5'b00111` and `title_rgb=5'b11000` → `vga_rgb` stays 11000 until the next strobe, then 00111.
- **Game over sequence:** assert `game_over` in PLAYING → GAME_OVER, `game_active` = 0. After 3 strobes → WAIT_RELEASE. Debounced switch low → TITLE.
- **Simultaneous events:** `game_over` rises in the same cycle as `sw_fall` → GAME_OVER, not TITLE.
- **Reset mid-operation:** assert `rst_n` = 0 during GAME_OVER → all outputs return to reset values immediately.
